// File: rtl/cat_classifier_apb.sv
// -----------------------------------------------------------------------------
// cat_classifier_apb
//
// APB-programmable single-neuron "cat" classifier. Software loads N_PIXELS
// signed pixels and weights plus a signed bias. A START write then runs one
// multiply-accumulate per clock, and the block reports sign(score) on CatRecOut
// with a one-cycle CatRecValid pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB requester inputs
//   PRDATA       registered read data, captured in the setup phase
//   PREADY       always 1 (no wait states)
//   CatRecOut    last classification result (1 = cat)
//   CatRecValid  one-cycle pulse when CatRecOut has been updated
//
// Register map (byte addresses)
//   0x0000 CTRL    bit0 START (write-1, self-clearing, reads 0)
//   0x0004 STATUS  bit0 BUSY, bit1 DONE (sticky until the next accepted START)
//   0x0008 BIAS    signed, ACC_WIDTH bits, sign-extended on read
//   0x000C SCORE   final accumulator of the last run (optional, see below)
//   0x1000+4*i     pixel i,  i < N_PIXELS
//   0x2000+4*i     weight i, i < N_PIXELS
//
// Optional feature
//   `define CAT_CLASSIFIER_SCORE_READ_EN adds the read-only SCORE register.
//   Without it, 0x000C reads as 0 and no SCORE storage exists.
// -----------------------------------------------------------------------------
module cat_classifier_apb #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int N_PIXELS        = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       CatRecOut,
  output logic                       CatRecValid
);

  // The accumulator is wide enough for N_PIXELS full-scale products plus bias.
  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N_PIXELS) + 1;
  localparam int IDX_W     = $clog2(N_PIXELS);
  localparam int PAGE_W    = AMBA_ADDR_WIDTH - 12;

  typedef enum logic [1:0] {IDLE, MAC, RESULT} state_t;

  state_t                        state, state_d;
  logic signed [ACC_WIDTH-1:0]   acc, acc_d;
  logic signed [ACC_WIDTH-1:0]   bias;
  logic [IDX_W-1:0]              cnt, cnt_d;
  logic                          done, done_d;
  logic                          out_d, valid_d;

  logic signed [DATA_WIDTH-1:0]  pix_mem [N_PIXELS];
  logic signed [DATA_WIDTH-1:0]  wt_mem  [N_PIXELS];

  logic                          aligned, idx_ok;
  logic [PAGE_W-1:0]             page;
  logic [9:0]                    word;
  logic [IDX_W-1:0]              mem_idx;
  logic                          sel_ctrl, sel_status, sel_bias, sel_score;
  logic                          sel_pix, sel_wt;
  logic                          wr_commit, rd_setup, busy, cfg_we, start;
  logic [AMBA_WORD-1:0]          rd_data;
  logic signed [2*DATA_WIDTH-1:0] prod;

`ifdef CAT_CLASSIFIER_SCORE_READ_EN
  logic signed [ACC_WIDTH-1:0]   score;
`endif

  assign PREADY = 1'b1;

  // Address decode: 4 KiB pages select control / pixel / weight space, and
  // the word offset inside a page is the element index.
  assign aligned    = (PADDR[1:0] == 2'b00);
  assign page       = PADDR[AMBA_ADDR_WIDTH-1:12];
  assign word       = PADDR[11:2];
  assign idx_ok     = (32'(word) < 32'(N_PIXELS));
  assign mem_idx    = word[IDX_W-1:0];
  assign sel_ctrl   = aligned && (page == PAGE_W'(0)) && (word == 10'd0);
  assign sel_status = aligned && (page == PAGE_W'(0)) && (word == 10'd1);
  assign sel_bias   = aligned && (page == PAGE_W'(0)) && (word == 10'd2);
  assign sel_score  = aligned && (page == PAGE_W'(0)) && (word == 10'd3);
  assign sel_pix    = aligned && (page == PAGE_W'(1)) && idx_ok;
  assign sel_wt     = aligned && (page == PAGE_W'(2)) && idx_ok;

  // Configuration writes are frozen while a computation is in flight so the
  // operands cannot change underneath the MAC loop.
  assign wr_commit = PSEL & PENABLE & PWRITE;
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign busy      = (state != IDLE);
  assign cfg_we    = wr_commit & ~busy;
  assign start     = cfg_we & sel_ctrl & PWDATA[0];

  // Operand memories carry no reset; software must load them before START.
  always_ff @(posedge clk) begin
    if (cfg_we && sel_pix) pix_mem[mem_idx] <= PWDATA[DATA_WIDTH-1:0];
    if (cfg_we && sel_wt)  wt_mem[mem_idx]  <= PWDATA[DATA_WIDTH-1:0];
  end

  // Read mux; anything unmapped or out of range reads as zero.
  always_comb begin
    rd_data = '0;
    if (sel_status)    rd_data = AMBA_WORD'({done, busy});
    else if (sel_bias) rd_data = AMBA_WORD'(bias);
    else if (sel_pix)  rd_data = AMBA_WORD'(pix_mem[mem_idx]);
    else if (sel_wt)   rd_data = AMBA_WORD'(wt_mem[mem_idx]);
    else if (sel_score) begin
`ifdef CAT_CLASSIFIER_SCORE_READ_EN
      rd_data = AMBA_WORD'(score);
`else
      rd_data = '0;
`endif
    end
  end

  // Operands are widened before multiplying so the signed product keeps
  // its full 2*DATA_WIDTH range.
  assign prod = (2*DATA_WIDTH)'(pix_mem[cnt]) * (2*DATA_WIDTH)'(wt_mem[cnt]);

  // Next-state logic. The result is registered on the RESULT cycle, so the
  // CatRecValid pulse lands N_PIXELS+1 cycles after the START edge.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    done_d  = done;
    out_d   = CatRecOut;
    valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          acc_d   = bias;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      MAC: begin
        acc_d = acc + ACC_WIDTH'(prod);
        cnt_d = cnt + IDX_W'(1);
        if (cnt == IDX_W'(N_PIXELS-1)) state_d = RESULT;
      end
      RESULT: begin
        out_d   = ~acc[ACC_WIDTH-1];
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      bias        <= '0;
      CatRecOut   <= 1'b0;
      CatRecValid <= 1'b0;
      PRDATA      <= '0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      cnt         <= cnt_d;
      done        <= done_d;
      CatRecOut   <= out_d;
      CatRecValid <= valid_d;
      if (cfg_we && sel_bias) bias <= ACC_WIDTH'($signed(PWDATA));
      if (rd_setup) PRDATA <= rd_data;
    end
  end

`ifdef CAT_CLASSIFIER_SCORE_READ_EN
  // SCORE snapshots the final accumulator when the result is published.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                score <= '0;
    else if (state == RESULT) score <= acc;
  end
`endif

endmodule

// File: tb/tb_cat_classifier_apb.sv
// -----------------------------------------------------------------------------
// tb_cat_classifier_apb
//
// Self-checking bench for cat_classifier_apb (N_PIXELS=4, DATA_WIDTH=8).
// A behavioural model tracks the register contents and each accepted job as
// "score = bias + sum(pixel*weight), published N+1 cycles after START". A
// per-cycle compare process checks CatRecValid/CatRecOut/PREADY against it,
// and every APB read is checked against the model. Directed scenarios are
// followed by randomized APB traffic.
// -----------------------------------------------------------------------------
module tb_cat_classifier_apb;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int ACCW = 2*DW + 2 + 1;

`ifdef CAT_CLASSIFIER_SCORE_READ_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, CatRecOut, CatRecValid;

  cat_classifier_apb #(
    .AMBA_WORD(32), .AMBA_ADDR_WIDTH(16), .DATA_WIDTH(DW), .N_PIXELS(N)
  ) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .CatRecOut(CatRecOut), .CatRecValid(CatRecValid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit checking = 1'b0;

  // Model state
  int m_pix [N];
  int m_wt  [N];
  int m_bias = 0;
  int m_pending = 0;
  int m_score = 0;
  int start_edge = -1;
  bit m_out = 1'b0;
  bit m_done = 1'b0;
  int valid_count = 0;
  int dut_valid_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sext(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = v & ((32'd1 << w) - 32'd1);
    if (m[w-1]) return int'(m) - (1 << w);
    return int'(m);
  endfunction

  // Busy as seen by an APB access whose committing edge is edge k.
  function automatic bit busyBefore(input int k);
    return (start_edge >= 0) && (k >= start_edge + 1) && (k <= start_edge + N + 1);
  endfunction

  function automatic void modelWrite(input int k, input logic [15:0] addr, input logic [31:0] data);
    int idx;
    int sum;
    if (busyBefore(k) || addr[1:0] != 2'b00) return;
    idx = int'(addr[11:2]);
    if (addr == 16'h0000 && data[0]) begin
      sum = m_bias;
      for (int i = 0; i < N; i++) sum += m_pix[i] * m_wt[i];
      m_pending  = sum;
      start_edge = k;
      m_done     = 1'b0;
    end else if (addr == 16'h0008) begin
      m_bias = sext(data, ACCW);
    end else if (addr[15:12] == 4'h1 && idx < N) begin
      m_pix[idx] = sext(data, DW);
    end else if (addr[15:12] == 4'h2 && idx < N) begin
      m_wt[idx] = sext(data, DW);
    end
  endfunction

  function automatic logic [31:0] modelRead(input int k, input logic [15:0] addr);
    int idx;
    if (addr[1:0] != 2'b00) return 32'd0;
    idx = int'(addr[11:2]);
    if (addr == 16'h0004) return {30'd0, m_done, busyBefore(k)};
    if (addr == 16'h0008) return 32'(m_bias);
    if (addr == 16'h000C) return SCORE_EN ? 32'(m_score) : 32'd0;
    if (addr[15:12] == 4'h1 && idx < N) return 32'(m_pix[idx]);
    if (addr[15:12] == 4'h2 && idx < N) return 32'(m_wt[idx]);
    return 32'd0;
  endfunction

  function automatic void modelReset();
    m_bias = 0; m_pending = 0; m_score = 0; start_edge = -1;
    m_out = 1'b0; m_done = 1'b0;
  endfunction

  // Per-cycle compare: retire a job on its publication cycle, then check.
  always @(negedge clk) begin
    logic exp_valid;
    if (checking) begin
      exp_valid = (start_edge >= 0) && (cyc == start_edge + N + 1);
      if (exp_valid) begin
        m_out      = (m_pending >= 0);
        m_done     = 1'b1;
        m_score    = m_pending;
        start_edge = -1;
      end
      if (CatRecValid === 1'b1) begin
        valid_count++;
        dut_valid_cyc = cyc;
      end
      checkOutput("valid", 32'(CatRecValid), 32'(exp_valid));
      checkOutput("cat_out", 32'(CatRecOut), 32'(m_out));
      checkOutput("pready", 32'(PREADY), 32'd1);
    end
  end

  // APB write; called and returning at posedge+1.
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    modelWrite(cyc, addr, data);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input string name, input logic [15:0] addr, output logic [31:0] data);
    logic [31:0] exp;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge clk); #1;
    exp = modelRead(cyc, addr);
    PENABLE = 1'b1;
    @(negedge clk);
    checkOutput(name, PRDATA, exp);
    data = PRDATA;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadVectors(input int p0, input int p1, input int p2, input int p3,
                             input int w, input int b);
    applyStimulus(16'h1000, 32'(p0));
    applyStimulus(16'h1004, 32'(p1));
    applyStimulus(16'h1008, 32'(p2));
    applyStimulus(16'h100C, 32'(p3));
    for (int i = 0; i < N; i++) applyStimulus(16'(16'h2000 + 4*i), 32'(w));
    applyStimulus(16'h0008, 32'(b));
  endtask

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 8))
      0: return 16'h0000;
      1: return 16'h0004;
      2: return 16'h0008;
      3: return 16'h000C;
      4: return 16'h0100;
      5: return 16'(16'h1000 + 4*$urandom_range(0, 5));
      6: return 16'(16'h2000 + 4*$urandom_range(0, 5));
      7: return 16'h1002;
      default: return 16'(16'h1000 + 4*$urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int se;
    int vc;
    rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    for (int i = 0; i < N; i++) begin m_pix[i] = 0; m_wt[i] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_out", 32'(CatRecOut), 32'd0);
    checkOutput("rst_valid", 32'(CatRecValid), 32'd0);
    checkOutput("rst_prdata", PRDATA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    checking = 1'b1;
    idle(1);
    apbRead("rst_status", 16'h0004, rd);
    apbRead("rst_bias", 16'h0008, rd);
    apbRead("rst_score", 16'h000C, rd);

    // Score exactly 0 -> cat
    $display("[TB] directed: bias -10");
    loadVectors(1, 2, 3, 4, 1, -10);
    apbRead("bias_rd", 16'h0008, rd);
    checkOutput("bias_lit", rd, 32'hFFFF_FFF6);
    applyStimulus(16'h0000, 32'd1);
    se = cyc;
    idle(7);
    checkOutput("latency_lit", 32'(dut_valid_cyc - se), 32'd5);
    checkOutput("out_lit_0", 32'(CatRecOut), 32'd1);
    apbRead("score_0", 16'h000C, rd);
    checkOutput("score_lit_0", rd, 32'd0);
    apbRead("status_done", 16'h0004, rd);
    checkOutput("status_lit", rd, 32'd2);

    // Score -1 -> not cat
    $display("[TB] directed: bias -11");
    applyStimulus(16'h0008, -32'sd11);
    applyStimulus(16'h0000, 32'd1);
    idle(7);
    checkOutput("out_lit_m1", 32'(CatRecOut), 32'd0);
    apbRead("score_m1", 16'h000C, rd);
    checkOutput("score_lit_m1", rd, SCORE_EN ? 32'hFFFF_FFFF : 32'd0);

    // Full-scale negative operands
    $display("[TB] directed: full scale");
    loadVectors(-128, -128, -128, -128, -128, 0);
    applyStimulus(16'h0000, 32'd1);
    idle(7);
    checkOutput("out_lit_big", 32'(CatRecOut), 32'd1);
    apbRead("score_big", 16'h000C, rd);
    checkOutput("score_lit_big", rd, SCORE_EN ? 32'd65536 : 32'd0);

    // Writes while busy are ignored
    $display("[TB] directed: writes while busy");
    loadVectors(5, 2, 3, 4, 1, -10);
    vc = valid_count;
    applyStimulus(16'h0000, 32'd1);
    applyStimulus(16'h1000, 32'd99);
    applyStimulus(16'h0000, 32'd1);
    idle(10);
    checkOutput("one_valid_lit", 32'(valid_count - vc), 32'd1);
    apbRead("pix0_kept", 16'h1000, rd);
    checkOutput("pix0_lit", rd, 32'd5);

    // Reset mid-computation
    $display("[TB] directed: reset during MAC");
    vc = valid_count;
    applyStimulus(16'h0000, 32'd1);
    idle(1);
    rst = 1'b0;
    modelReset();
    idle(2);
    rst = 1'b1;
    idle(6);
    checkOutput("abort_valid_lit", 32'(valid_count - vc), 32'd0);
    checkOutput("abort_out_lit", 32'(CatRecOut), 32'd0);
    apbRead("abort_status", 16'h0004, rd);
    checkOutput("abort_status_lit", rd, 32'd0);
    applyStimulus(16'h0008, -32'sd10);
    applyStimulus(16'h0000, 32'd1);
    idle(7);
    checkOutput("rerun_out_lit", 32'(CatRecOut), 32'd1);

    // Unmapped and out-of-range accesses
    $display("[TB] directed: unmapped accesses");
    apbRead("oor_pix", 16'h1010, rd);
    checkOutput("oor_pix_lit", rd, 32'd0);
    apbRead("unmapped", 16'h0100, rd);
    checkOutput("unmapped_lit", rd, 32'd0);
    applyStimulus(16'h1010, 32'd55);
    applyStimulus(16'h0100, 32'd1);
    applyStimulus(16'h2010, 32'd77);
    for (int i = 0; i < N; i++) apbRead("mem_kept", 16'(16'h1000 + 4*i), rd);
    apbRead("bias_kept", 16'h0008, rd);

    // Randomized traffic
    $display("[TB] random phase");
    for (int it = 0; it < 60; it++) begin
      logic [15:0] a;
      logic [31:0] d;
      int op;
      op = $urandom_range(0, 9);
      a  = randAddr();
      d  = $urandom;
      if (a == 16'h0008) d = 32'($urandom_range(0, 200000)) - 32'd100000;
      if (op < 4) applyStimulus(a, d);
      else if (op < 7) apbRead("rand_read", a, rd);
      else if (op < 9) begin
        applyStimulus(16'h0000, 32'd1);
        repeat ($urandom_range(0, 2)) apbRead("busy_read", randAddr(), rd);
      end else idle($urandom_range(1, 6));
    end
    idle(8);
    apbRead("final_status", 16'h0004, rd);
    apbRead("final_score", 16'h000C, rd);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
